// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first, fixed WIDTH-cycle latency.
// Optional signed-overflow output is built only when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_start,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_s,
    output logic             out_po,
    output logic             out_ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               po_q, po_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic b_bit;
    logic fa_sum;
    logic fa_cout;
    logic last_bit;

    // Subtraction is a + ~b + 1: the +1 comes from the carry seeded with in_mode.
    always_comb begin
        b_bit    = b_q[0] ^ mode_q;
        fa_sum   = a_q[0] ^ b_bit ^ carry_q;
        fa_cout  = (a_q[0] & b_bit) | (carry_q & (a_q[0] ^ b_bit));
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        s_d     = s_q;
        po_d    = po_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    mode_d  = in_mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                    carry_d = in_mode;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    cnt_d   = '0;
                    s_d     = {fa_sum, acc_q[WIDTH-1:1]};
                    po_d    = fa_cout ^ mode_q;
`ifdef SERIAL_ADDSUB_OVF_EN
                    // carry_q here is the carry into the MSB stage
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            po_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            po_q    <= po_d;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    assign out_busy = (state_q == S_RUN);
    assign out_done = (state_q == S_DONE);
    assign out_s    = s_q;
    assign out_po   = po_q;

endmodule
